uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver with 16x oversampling and an integrated receive FIFO; the counterpart of the team's uart_tx.
- Samples the asynchronous serial line and reassembles 8N1 frames, LSB first.
- Pushes completed bytes into a wrap_around_fifo instance.
- Raises one-cycle status pulses on framing error and overrun.
- Sits between the board-level RX pin and the consumer logic that drains the FIFO.

Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: line bit rate.
- DATA_WIDTH, 8: data bits per frame; must be 2^n.
- FIFO_DEPTH, 16: receive FIFO entries.
- OVERSAMPLE, 16: sample ticks per bit.

Ports:
- clk_i  input  1  system clock; all logic on its rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- rx_en_i  input  1  receive enable.
- rx_bit_i  input  1  serial line, asynchronous, idle high.
- rx_ren_i  input  1  FIFO read request.
- dout_o  output  DATA_WIDTH  read data.
- empty_o  output  1  FIFO empty.
- full_o  output  1  FIFO full.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- overrun_o  output  1  one-cycle pulse: byte dropped because FIFO was full.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all counters 0; synchronizer flops =1.
  - FIFO emptied: empty_o=1, full_o=0.
  - dout_o=0, frame_err_o=0, overrun_o=0.
- Input synchronization: rx_bit_i passes through a 2-flop synchronizer, reset value 1. All decisions use the synchronized value (rx_s).
- Tick generator:
  - TICK_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division; 27 at defaults.
  - Counter runs 0..TICK_DIV-1; tick asserts for one cycle at TICK_DIV-1.
  - Counter held at 0 in IDLE.
  - One bit time = TICK_DIV*OVERSAMPLE clocks (432 at defaults).
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If rx_en_i=1 and rx_s falls 1->0: go to START; tick counter and sample counter cleared.
  - If rx_en_i=0: falling edges are ignored.
- START:
  - At sample count OVERSAMPLE/2-1 (mid start bit), re-check rx_s.
  - rx_s=1 (glitch/false start): return to IDLE, nothing written.
  - rx_s=0: clear sample counter and bit counter, go to DATA.
- DATA:
  - Sample rx_s at sample count OVERSAMPLE-1 (mid bit).
  - Shift the sample into shift_reg[MSB]; shift right, so LSB arrives first.
  - After DATA_WIDTH bits, go to STOP.
- STOP, at mid stop bit:
  - rx_s=1 and FIFO not full: assert FIFO write of shift_reg for one cycle.
  - rx_s=1 and FIFO full: no write; overrun_o pulses.
  - rx_s=0: no write; frame_err_o pulses.
  - All cases return to IDLE on the next cycle. The next frame is detectable from the half-stop point, which tolerates up to about 2.5% baud mismatch.
- rx_en_i deasserted mid-frame: the current frame completes normally; only new starts are blocked.
- Read side:
  - rx_ren_i with empty_o=0 pops the FIFO; dout_o is registered and updates on the following clock edge.
  - rx_ren_i while empty_o=1 is ignored; dout_o holds.
- Simultaneous FIFO write and read: both happen in the same cycle; occupancy is unchanged.
- Status timing:
  - empty_o deasserts one cycle after the write cycle.
  - full_o asserts when FIFO_DEPTH entries are held.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP, sampled at mid bit.
  - Even parity: XOR of data bits and parity bit must be 0.
  - Adds output parity_err_o, 1 bit, reset 0. It pulses one cycle at mid stop bit if parity mismatched; the byte is then not written.
  - Framing error takes precedence; only frame_err_o pulses when both errors occur.
- Undefined: no PARITY state; parity_err_o port is absent; frame format is 8N1.

Test Plan:
- Reset, then send 0xA5 at 432 clocks/bit with rx_en_i=1 -> empty_o falls about 9.5 bit times after the start edge; rx_ren_i pulse -> dout_o=0xA5 next cycle; empty_o=1.
- Send 0x00, 0xFF, 0x55 back-to-back, each with a one-bit stop -> three FIFO entries read in order; no error pulses.
- 100-clock low glitch on idle line -> no state change beyond START; FIFO stays empty; no error pulses.
- Frame 0x3C with stop bit driven 0 -> frame_err_o one-cycle pulse; FIFO stays empty; next valid frame 0x81 received correctly.
- Fill 16 bytes with no reads -> full_o=1; a 17th frame produces an overrun_o pulse; reading 16 returns the first 16 bytes intact.
- Assert rst_ni=0 during DATA of frame 0x5A -> outputs at reset values immediately; after release, frame 0xC3 received correctly. With UART_RX_PARITY_EN defined, 0x01 with parity bit 0 -> parity_err_o pulse, no write.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx (with helper wrap_around_fifo)                     |
// | Description : 16x-oversampling UART receiver feeding a receive FIFO.     |
// |               Optional even-parity frame enabled by UART_RX_PARITY_EN.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module wrap_around_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] c_ADDR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] c_COUNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = rd_en_i && (r_count != '0);
  assign w_push = wr_en_i && (r_count != c_COUNT_FULL);

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == c_ADDR_LAST) ? '0 : r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr    <= (r_rptr == c_ADDR_LAST) ? '0 : r_rptr + 1'b1;
        r_rd_data <= r_mem[r_rptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data_o = r_rd_data;
  assign empty_o   = (r_count == '0);
  assign full_o    = (r_count == c_COUNT_FULL);
endmodule

module uart_rx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_en_i,
  input  logic                  rx_bit_i,
  input  logic                  rx_ren_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic                  parity_err_o
`endif
);
  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH);

  localparam logic [TW-1:0] c_TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] c_SAMPLE_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] c_SAMPLE_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] c_BIT_LAST    = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] c_PARITY = 3'd4;
`endif

  logic [2:0]            r_state;
  logic [1:0]            r_sync;
  logic                  r_rx_prev;
  logic [TW-1:0]         r_tick_cnt;
  logic [SW-1:0]         r_sample_cnt;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_frame_err;
  logic                  r_overrun;
  logic                  w_rx_s;
  logic                  w_tick;
  logic                  w_mid_bit;
  logic                  w_stop_mid;
  logic                  w_wr;
  logic                  w_full;
  logic                  w_par_bad;

`ifdef UART_RX_PARITY_EN
  logic r_par;
  logic r_parity_err;
  assign w_par_bad    = ^{r_shift, r_par};
  assign parity_err_o = r_parity_err;
`else
  assign w_par_bad = 1'b0;
`endif

  assign w_rx_s     = r_sync[1];
  assign w_tick     = (r_state != c_IDLE) && (r_tick_cnt == c_TICK_LAST);
  assign w_mid_bit  = w_tick && (r_sample_cnt == c_SAMPLE_LAST);
  assign w_stop_mid = (r_state == c_STOP) && w_mid_bit;
  assign w_wr       = w_stop_mid && w_rx_s && !w_par_bad && !w_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= c_IDLE;
      r_sync       <= 2'b11;
      r_rx_prev    <= 1'b1;
      r_tick_cnt   <= '0;
      r_sample_cnt <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_sync      <= {r_sync[0], rx_bit_i};
      r_rx_prev   <= w_rx_s;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (r_state == c_IDLE || w_tick) r_tick_cnt <= '0;
      else                             r_tick_cnt <= r_tick_cnt + 1'b1;

      case (r_state)
        c_IDLE: begin
          if (rx_en_i && r_rx_prev && !w_rx_s) begin
            r_state      <= c_START;
            r_sample_cnt <= '0;
          end
        end
        c_START: begin
          if (w_tick) begin
            if (r_sample_cnt == c_SAMPLE_HALF) begin
              r_sample_cnt <= '0;
              r_bit_cnt    <= '0;
              r_state      <= w_rx_s ? c_IDLE : c_DATA;
            end else begin
              r_sample_cnt <= r_sample_cnt + 1'b1;
            end
          end
        end
        c_DATA: begin
          if (w_mid_bit) begin
            r_sample_cnt <= '0;
            r_shift      <= {w_rx_s, r_shift[DATA_WIDTH-1:1]};
            if (r_bit_cnt == c_BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              r_state <= c_PARITY;
`else
              r_state <= c_STOP;
`endif
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else if (w_tick) begin
            r_sample_cnt <= r_sample_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        c_PARITY: begin
          if (w_mid_bit) begin
            r_sample_cnt <= '0;
            r_par        <= w_rx_s;
            r_state      <= c_STOP;
          end else if (w_tick) begin
            r_sample_cnt <= r_sample_cnt + 1'b1;
          end
        end
`endif
        c_STOP: begin
          // Leaving at mid stop bit lets the next start edge be caught early.
          if (w_mid_bit) begin
            r_sample_cnt <= '0;
            r_state      <= c_IDLE;
            if (!w_rx_s) r_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            else if (w_par_bad) r_parity_err <= 1'b1;
`endif
            else if (w_full) r_overrun <= 1'b1;
          end else if (w_tick) begin
            r_sample_cnt <= r_sample_cnt + 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  wrap_around_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (w_wr),
    .wr_data_i (r_shift),
    .rd_en_i   (rx_ren_i),
    .rd_data_o (dout_o),
    .empty_o   (empty_o),
    .full_o    (w_full)
  );

  assign full_o      = w_full;
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;
endmodule

`default_nettype wire
